fifo_4b: RTL and testbench

- Parameterised-depth FIFO of 4-bit entries with val/rdy handshakes on both ends.
- Enqueue side is the producer interface: a registered write with enable, as the team's 4-bit register already provides.
- Dequeue side is the consumer/reader end of that interface.
- Used to decouple a 4-bit producer from a consumer that may stall.

---
 rtl/fifo_4b.sv | 62 ++++++
 tb/tb_fifo_4b.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fifo_4b.sv
// Circular-buffer FIFO of 4-bit entries with val/rdy on both ends.
// Occupancy is tracked by count; pointers only address storage.
module fifo_4b #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [3:0]                 enq_msg,
    output logic                       deq_val,
    input  logic                       deq_rdy,
    output logic [3:0]                 deq_msg,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          enq_fire;
    logic          deq_fire;

    // Ready/valid depend only on registered count, never on the far side.
    assign enq_rdy  = (count != CW'(DEPTH)) & !reset;
    assign deq_val  = (count != '0) & !reset;
    assign enq_fire = enq_val & enq_rdy;
    assign deq_fire = deq_val & deq_rdy;
    assign deq_msg  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[wr_ptr] <= enq_msg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire)
                wr_ptr <= wr_ptr + PW'(1);
            if (deq_fire)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            unique case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_4b.sv
// Directed table-driven bench for fifo_4b at DEPTH=4.
// Each row: inputs for one cycle and outputs expected before its edge.
module tb_fifo_4b;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enq_val = 1'b0;
    logic       enq_rdy;
    logic [3:0] enq_msg = 4'h0;
    logic       deq_val;
    logic       deq_rdy = 1'b0;
    logic [3:0] deq_msg;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         rst;
        bit         ev;
        logic [3:0] em;
        bit         dr;
        bit         erdy;
        bit         dval;
        logic [3:0] dmsg;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    fifo_4b #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .enq_val (enq_val),
        .enq_rdy (enq_rdy),
        .enq_msg (enq_msg),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Occupancy must stay within 0..DEPTH; underflow would wrap above DEPTH.
    always @(posedge clk) begin
        if (!reset && !$isunknown(count)) begin
            checks++;
            assert (int'(count) <= DEPTH)
            else begin
                errors++;
                $display("FAIL count_bound: count=%0d limit=%0d", count, DEPTH);
            end
        end
    end

    function automatic void add(bit rst, bit ev, logic [3:0] em, bit dr,
                                bit erdy, bit dval, logic [3:0] dmsg, int cnt);
        vec_t v;
        v.rst = rst; v.ev = ev; v.em = em; v.dr = dr;
        v.erdy = erdy; v.dval = dval; v.dmsg = dmsg; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(bit rst, bit ev, logic [3:0] em, bit dr);
        @(posedge clk);
        #1;
        reset   = rst;
        enq_val = ev;
        enq_msg = em;
        deq_rdy = dr;
    endtask

    task automatic check_now(int idx, bit erdy, bit dval,
                             logic [3:0] dmsg, int cnt);
        chk("enq_rdy", idx, int'(enq_rdy), int'(erdy));
        chk("deq_val", idx, int'(deq_val), int'(dval));
        if (dval)
            chk("deq_msg", idx, int'(deq_msg), int'(dmsg));
        if (cnt >= 0)
            chk("count", idx, int'(count), cnt);
    endtask

    initial begin
        bit seen;

        // reset two cycles, then idle
        add(1, 0, 4'h0, 0, 0, 0, 4'h0, -1);
        add(1, 0, 4'h0, 0, 0, 0, 4'h0, 0);
        add(0, 0, 4'h0, 0, 1, 0, 4'h0, 0);
        // single pass-through; empty keeps deq_val low despite enq_val
        add(0, 1, 4'hA, 0, 1, 0, 4'h0, 0);
        add(0, 0, 4'h0, 0, 1, 1, 4'hA, 1);
        add(0, 0, 4'h0, 1, 1, 1, 4'hA, 1);
        add(0, 0, 4'h0, 0, 1, 0, 4'h0, 0);
        // fill to full, fifth enq refused
        add(0, 1, 4'h1, 0, 1, 0, 4'h0, 0);
        add(0, 1, 4'h2, 0, 1, 1, 4'h1, 1);
        add(0, 1, 4'h3, 0, 1, 1, 4'h1, 2);
        add(0, 1, 4'h4, 0, 1, 1, 4'h1, 3);
        add(0, 1, 4'h5, 0, 0, 1, 4'h1, 4);
        // full with simultaneous deq: only deq fires
        add(0, 1, 4'h5, 1, 0, 1, 4'h1, 4);
        add(0, 0, 4'h0, 0, 1, 1, 4'h2, 3);
        // drain remainder; 5 must not appear
        add(0, 0, 4'h0, 1, 1, 1, 4'h2, 3);
        add(0, 0, 4'h0, 1, 1, 1, 4'h3, 2);
        add(0, 0, 4'h0, 1, 1, 1, 4'h4, 1);
        add(0, 0, 4'h0, 0, 1, 0, 4'h0, 0);
        // streaming 0..11, pointers wrap three times
        for (int k = 0; k < 12; k++) begin
            if (k == 0)
                add(0, 1, 4'(k), 1, 1, 0, 4'h0, 0);
            else
                add(0, 1, 4'(k), 1, 1, 1, 4'(k - 1), 1);
        end
        add(0, 0, 4'h0, 1, 1, 1, 4'hB, 1);
        add(0, 0, 4'h0, 0, 1, 0, 4'h0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ev, vecs[i].em, vecs[i].dr);
            @(negedge clk);
            check_now(i, vecs[i].erdy, vecs[i].dval,
                      vecs[i].dmsg, vecs[i].cnt);
        end

        // reset mid-operation with three entries held
        drive(0, 1, 4'hC, 0);
        drive(0, 1, 4'hD, 0);
        drive(0, 1, 4'hE, 0);
        drive(1, 0, 4'h0, 0);
        @(negedge clk);
        check_now(100, 0, 0, 4'h0, 3);
        drive(0, 0, 4'h0, 0);
        @(negedge clk);
        check_now(101, 1, 0, 4'h0, 0);
        drive(0, 1, 4'h7, 0);
        drive(0, 0, 4'h0, 0);
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            if (deq_val)
                seen = 1'b1;
            else
                @(posedge clk);
        end
        chk("deq_val_wait", 102, int'(seen), 1);
        if (seen) begin
            check_now(103, 1, 1, 4'h7, 1);
            drive(0, 0, 4'h0, 1);
            @(negedge clk);
            check_now(104, 1, 1, 4'h7, 1);
            drive(0, 0, 4'h0, 0);
            @(negedge clk);
            check_now(105, 1, 0, 4'h0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
